// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {cout, sum} = a + b + cin, one bit per clock, LSB first.
// A single full-adder cell and a carry flop walk the operands; the result registers
// are only updated on the edge that enters DONE so they stay stable during RUN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  s_sr_q, s_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              bit_s;
  logic              bit_c;
  logic              last_bit;

  // Full-adder cell on the current LSBs and the running carry.
  assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Next-state and datapath updates; everything holds by default.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = {bit_s, s_sr_q[WIDTH-1:1]};
        carry_d = bit_c;
        if (last_bit) begin
          // carry_q here is the carry into the MSB; XOR with carry out flags signed overflow.
          sum_d   = {bit_s, s_sr_q[WIDTH-1:1]};
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, randomized 8-bit operations
// and an exhaustive 3-bit sweep, all compared against an arithmetic reference.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = '0;
  logic [2:0] b3 = '0;
  logic       cin3 = 1'b0;
  logic       busy3, done3, cout3, ovf3;
  logic [2:0] sum3;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Last result the reference says the 8-bit DUT should be holding.
  int unsigned last_sum = 0;
  int unsigned last_cout = 0;
  int unsigned last_ovf = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .a        (a3),
    .b        (b3),
    .cin      (cin3),
    .busy     (busy3),
    .done     (done3),
    .sum      (sum3),
    .cout     (cout3),
    .overflow (ovf3)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow from the signed interpretation.
  task automatic ref_add(input int w, input int unsigned a, input int unsigned b,
                         input int unsigned c, output int unsigned s,
                         output int unsigned co, output int unsigned ov);
    int unsigned full;
    int sa, sb, r;
    full = a + b + c;
    s    = full % (32'd1 << w);
    co   = (full >> w) & 32'd1;
    sa   = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb   = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    r    = sa + sb + int'(c);
    ov   = (r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1))) ? 1 : 0;
  endtask

  // One 8-bit operation. With noise set, start stays high and the operand
  // inputs change for the whole operation; the caller's next op is then the
  // one accepted at the first IDLE edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit noise);
    int unsigned es, eco, eov;
    int busy_cnt, done_cnt, done_at;
    ref_add(8, a, b, c, es, eco, eov);
    @(negedge clk);
    a8 = a;
    b8 = b;
    cin8 = c;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_after_start", busy8, 1);
    busy_cnt = 1;
    done_cnt = 0;
    done_at  = -1;
    if (noise) begin
      a8 = 8'hAA;
      b8 = 8'h55;
      cin8 = 1'b1;
    end else begin
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
    end
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < 8) check_eq("sum_hold_in_run", sum8, last_sum);
      if (k == 8) begin
        check_eq("sum", sum8, es);
        check_eq("cout", cout8, eco);
        check_eq("overflow", ovf8, eov);
      end
    end
    check_eq("done_latency", done_at, 8);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("busy_cycles", busy_cnt, 9);
    last_sum  = es;
    last_cout = eco;
    last_ovf  = eov;
  endtask

  // One 3-bit operation for the exhaustive sweep.
  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
    int unsigned es, eco, eov;
    int done_at;
    ref_add(3, a, b, c, es, eco, eov);
    @(negedge clk);
    a3 = a;
    b3 = b;
    cin3 = c;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (done3 && done_at < 0) begin
        done_at = k;
        check_eq("w3_cout_sum", {cout3, sum3}, {eco[0], es[2:0]});
        check_eq("w3_overflow", ovf3, eov);
      end
    end
    check_eq("w3_done_latency", done_at, 3);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         n;

    // Reset behaviour.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_outputs", {sum8, cout8, ovf8}, 10'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) n++;
    end
    check_eq("idle_no_activity", n, 0);
    check_eq("idle_outputs", {sum8, cout8, ovf8}, 10'h0);

    // Directed cases.
    op8(8'h3C, 8'h15, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 1'b1);
    op8(8'hAA, 8'h55, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Abort by reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'h3C;
    b8 = 8'h15;
    cin8 = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy8, 0);
    check_eq("abort_done", done8, 0);
    check_eq("abort_outputs", {sum8, cout8, ovf8}, 10'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = 0;
    last_cout = 0;
    last_ovf = 0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) n++;
    end
    check_eq("abort_no_done", n, 0);
    op8(8'h01, 8'h02, 1'b0, 1'b0);

    // Randomized 8-bit operations.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      op8(ra, rb, rc, 1'b0);
    end

    // Exhaustive 3-bit sweep.
    for (int i = 0; i < 128; i++) begin
      op3(i[2:0], i[5:3], i[6]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
